// File: rtl/change_event_fifo_pkg.sv
// Shared types and default sizing for the change-event capture path.
// The event record packs the observed value above its cycle timestamp.
package monitor_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_TS_WIDTH  = 32;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_CNT_WIDTH = 16;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]    value;
        logic [DEF_TS_WIDTH-1:0] timestamp;
    } change_event_t;

endpackage

// File: rtl/change_event_fifo_if.sv
// Valid/ready drain port between the event FIFO (master) and the collector (slave).
interface change_event_if
    import monitor_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TS_WIDTH = DEF_TS_WIDTH
) ();

    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_value;
    logic [TS_WIDTH-1:0] out_timestamp;

    modport master (output out_valid, output out_value, output out_timestamp, input out_ready);
    modport slave  (input out_valid, input out_value, input out_timestamp, output out_ready);

endinterface

// File: rtl/change_event_fifo_sync_fifo.sv
// First-word-fall-through FIFO with an extra pointer wrap bit for full/empty.
// The head word is kept in a register so it reads 0 after reset and holds when empty.
module sync_fifo
    import monitor_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_WIDTH + DEF_TS_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_pop,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_push;
    logic                  w_pop;
    logic [AW:0]           w_wr_ptr_next;
    logic [AW:0]           w_rd_ptr_next;

    assign o_empty = (r_rd_ptr == r_wr_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    assign w_pop         = i_pop && !o_empty;
    assign w_push        = i_push && (!o_full || w_pop);
    assign w_wr_ptr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_ptr_next = r_rd_ptr + {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            // Next head is the word being written this edge if it lands in the head slot.
            if (w_rd_ptr_next != w_wr_ptr_next) begin
                r_rd_data <= (w_push && (w_rd_ptr_next == r_wr_ptr)) ?
                             i_wr_data : r_mem[w_rd_ptr_next[AW-1:0]];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/change_event_fifo.sv
// Detects changes of a monitored value, timestamps them and queues them for the
// software collector; events that meet a full queue are counted and flagged.
module change_event_fifo
    import monitor_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         sample_in,
    change_event_if.master           out_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]     drop_count,
    output logic                     overflow
);

    logic [TS_WIDTH-1:0]       r_ts;
    logic [WIDTH-1:0]          r_prev;
    logic                      r_primed;
    logic [CNT_WIDTH-1:0]      r_drop_count;
    logic                      r_overflow;

    logic                      w_event;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_full;
    logic                      w_empty;
    logic [WIDTH+TS_WIDTH-1:0] w_rd_data;

    assign w_event = enable && (!r_primed || (sample_in != r_prev));
    assign w_pop   = !w_empty && out_if.out_ready;
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts         <= '0;
            r_prev       <= '0;
            r_primed     <= 1'b0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            // Disabling forgets the primed state so re-enabling reports the value again.
            if (enable) begin
                r_prev   <= sample_in;
                r_primed <= 1'b1;
            end else begin
                r_primed <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != {CNT_WIDTH{1'b1}}) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (WIDTH + TS_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data ({sample_in, r_ts}),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    assign out_if.out_valid     = !w_empty;
    assign out_if.out_value     = w_rd_data[TS_WIDTH +: WIDTH];
    assign out_if.out_timestamp = w_rd_data[TS_WIDTH-1:0];
    assign drop_count           = r_drop_count;
    assign overflow             = r_overflow;

endmodule

// File: tb/tb_change_event_fifo.sv
// Directed scenarios plus a randomized run of change_event_fifo, each cycle
// compared against a queue-based reference of the capture rules.
module tb_change_event_fifo;
    import monitor_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] sample_in = '0;
    logic [3:0]  level;
    logic [15:0] drop_count;
    logic        overflow;

    change_event_if #(.WIDTH(32), .TS_WIDTH(32)) out_if ();

    change_event_fifo #(
        .WIDTH     (32),
        .TS_WIDTH  (32),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sample_in  (sample_in),
        .out_if     (out_if),
        .level      (level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    change_event_t mq[$];
    logic [31:0]   m_ts;
    logic [31:0]   m_prev;
    bit            m_primed;
    int            m_drops;
    bit            m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts     = '0;
        m_prev   = '0;
        m_primed = 1'b0;
        m_drops  = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_model();
        chk("valid", out_if.out_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("drops", drop_count, m_drops);
        chk("overflow", overflow, m_ovf);
        if (mq.size() != 0) begin
            chk("head_value", out_if.out_value, mq[0].value);
            chk("head_ts", out_if.out_timestamp, mq[0].timestamp);
        end
    endtask

    // One clock with the currently driven inputs, then compare against the model.
    task automatic step();
        bit            ev;
        bit            pop;
        bit            full;
        change_event_t e;
        pop  = (mq.size() > 0) && out_if.out_ready;
        full = (mq.size() == DEPTH);
        ev   = enable && (!m_primed || (sample_in != m_prev));
        e.value     = sample_in;
        e.timestamp = m_ts;
        if (enable) begin
            m_prev   = sample_in;
            m_primed = 1'b1;
        end else begin
            m_primed = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (!full || pop) begin
                mq.push_back(e);
            end else begin
                if (m_drops != 16'hFFFF) m_drops++;
                m_ovf = 1'b1;
            end
        end
        m_ts = m_ts + 1;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic [31:0] ts_a;

    initial begin
        out_if.out_ready = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_valid", out_if.out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_value", out_if.out_value, 0);
        chk("rst_ts", out_if.out_timestamp, 0);
        rst = 1'b0;

        // Constant value after reset: exactly one entry {5, 0}
        enable = 1'b1;
        sample_in = 32'd5;
        step();
        chk("t1_value", out_if.out_value, 5);
        chk("t1_ts", out_if.out_timestamp, 0);
        repeat (20) step();
        chk("t1_level", level, 1);

        // Counter input with ready held: value tracks timestamp, never backs up
        out_if.out_ready = 1'b1;
        sample_in = m_ts;
        step();
        repeat (30) begin
            sample_in = m_ts;
            step();
            chk("t2_val_eq_ts", out_if.out_value, out_if.out_timestamp);
            chk("t2_level_le1", level <= 1, 1);
        end
        chk("t2_drops", drop_count, 0);

        // 12 changes into a stalled FIFO
        do_reset();
        out_if.out_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample_in = 32'd100 + i;
            step();
        end
        chk("t3_level", level, 8);
        chk("t3_drops", drop_count, 4);
        chk("t3_ovf", overflow, 1);
        enable = 1'b0;
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_order", out_if.out_value, 32'd100 + i);
            step();
        end
        chk("t3_drained", level, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Full FIFO with a change and a pop on the same edge
        do_reset();
        out_if.out_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample_in = 32'd200 + i;
            step();
        end
        sample_in = 32'd300;
        out_if.out_ready = 1'b1;
        step();
        chk("t4_level", level, 8);
        chk("t4_drops", drop_count, 0);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", out_if.out_value, (i < 7) ? 32'd201 + i : 32'd300);
            step();
        end

        // Enable toggle with a constant value
        do_reset();
        out_if.out_ready = 1'b0;
        sample_in = 32'd9;
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        repeat (3) step();
        chk("t5_level", level, 2);
        chk("t5_v0", out_if.out_value, 9);
        chk("t5_ts0", out_if.out_timestamp, 0);
        ts_a = out_if.out_timestamp;
        out_if.out_ready = 1'b1;
        enable = 1'b0;
        step();
        chk("t5_v1", out_if.out_value, 9);
        chk("t5_ts1", out_if.out_timestamp, 2);
        chk("t5_ts_distinct", out_if.out_timestamp != ts_a, 1);

        // Asynchronous reset mid-burst
        do_reset();
        out_if.out_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = 32'd400 + i;
            step();
        end
        chk("t6_level_pre", level, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", out_if.out_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_drops", drop_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sample_in = 32'd77;
        step();
        chk("t6_value", out_if.out_value, 77);
        chk("t6_ts", out_if.out_timestamp, 0);

        // Randomized traffic with varying drain pressure
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            int ready_pct;
            ready_pct = $urandom_range(0, 100);
            repeat (60) begin
                enable           = ($urandom_range(0, 9) != 0);
                sample_in        = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
                out_if.out_ready = ($urandom_range(0, 99) < ready_pct);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/change_event_fifo.md
# change_event_fifo

Capture stage between a free-running design counter and the DPI software monitor. Watches a monitored value every clock, detects changes, and queues each change with a cycle timestamp in a small FIFO. Entries drain through a valid/ready port to the passive collector interface, which makes the `c_monitor` call only when it accepts an entry. The FIFO decouples bursty value changes from the software side and reports overflow explicitly.

## Interface
- `WIDTH`, 32: width of the monitored value.
- `TS_WIDTH`, 32: width of the timestamp counter.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 16: width of the drop counter.

- `clk` input 1: the single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: capture enable; when low, no changes are detected or queued.
- `sample_in` input WIDTH: monitored value, e.g. the design's cycle counter.
- `out_valid` output 1: FIFO head holds an entry.
- `out_ready` input 1: consumer accepts the head this cycle.
- `out_value` output WIDTH: value field of the head entry.
- `out_timestamp` output TS_WIDTH: timestamp field of the head entry.
- `level` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `drop_count` output CNT_WIDTH: number of events lost to a full FIFO; saturating.
- `overflow` output 1: sticky flag, set on the first drop.

## Operation
- Reset values:
  - `out_valid`=0, `level`=0, `drop_count`=0, `overflow`=0.
  - `out_value` and `out_timestamp` read 0.
  - Internal `ts_q`=0, `prev_q`=0, `primed_q`=0.
- Timestamp: `ts_q` increments every cycle regardless of `enable`. It wraps modulo 2^TS_WIDTH without any flag.
- Change detection, evaluated at each edge while `enable`=1:
  - Event if `primed_q`=0. The first enabled edge always reports the initial value.
  - Event if `sample_in` != `prev_q`.
  - On every enabled edge: `prev_q` <= `sample_in` and `primed_q` <= 1.
- `enable`=0 clears `primed_q`. Re-enabling therefore reports the current value once, even if it is unchanged.
- Event entry = {`sample_in`, `ts_q`}, both sampled at the same edge.
- Push/pop:
  - A pop occurs when `out_valid` && `out_ready`.
  - A push occurs on an event when not full, or when full with a pop at the same edge.
  - A simultaneous push and pop leaves `level` unchanged. Order is preserved.
- Drop: an event while full with no pop.
  - The entry is discarded.
  - `drop_count` increments and saturates at all-ones.
  - `overflow` is set and stays set until `rst`.
- Output is first-word-fall-through: `out_value` and `out_timestamp` show the head whenever `out_valid`=1. They hold while `out_valid`=1 && `out_ready`=0.
- When empty, outputs hold their last value. The consumer must not sample them.
- `out_ready` while empty has no effect.
- Reset mid-operation flushes every entry immediately and asynchronously. It clears the counters and the flag, and restarts the timestamp at 0.

## Timing
- Capture latency: an event at edge N gives `out_valid`=1 in cycle N→N+1 if the FIFO was empty. The entry carries `out_timestamp` = the `ts_q` value before edge N.
- Throughput: one push and one pop per cycle. With `out_ready` held at 1, a change every cycle never fills the FIFO.
- `level` and `out_valid` are registered/derived from pointers, with no combinational path from `out_ready`.
- The only combinational input-to-output path is none: `out_valid` does not depend on `out_ready`.
- Pointers are $clog2(DEPTH)+1 bits. Full/empty come from the MSB comparison, and wrap-around is exercised by design.

## Structure
- Package `monitor_pkg`:
  - `typedef struct packed { logic [WIDTH-1:0] value; logic [TS_WIDTH-1:0] timestamp; } change_event_t`, using package-default widths.
  - Default constants for `DEPTH` and `CNT_WIDTH`.
- Sub-module `sync_fifo` (parameters: data width, DEPTH):
  - Storage array, read/write pointers, `level`, `full`, `empty`, FWFT read.
  - Async active-high reset.
- `change_event_fifo` holds the change detector, timestamp counter, drop logic, and one `sync_fifo` instance.

## Test plan
- Reset release with `enable`=1 and `sample_in`=5 held constant: one entry {5, ts=0} appears at the first edge, then no further entries for 20 cycles.
- `sample_in` = cycle counter 0,1,2,… with `out_ready`=1: entries arrive every cycle with value == timestamp; `level` ≤ 1; `drop_count`=0.
- `out_ready`=0, 12 consecutive changes with DEPTH=8:
  - `level`=8, `drop_count`=4, `overflow`=1.
  - Draining yields the first 8 values in order.
- Full FIFO with a simultaneous change and pop: `level` stays 8, no drop, and the new entry emerges last.
- `enable` toggled 1→0→1 with `sample_in`=9 constant: exactly two entries for value 9, with distinct timestamps.
- Assert `rst` mid-burst with `level`=5: immediately `out_valid`=0, `level`=0, `drop_count`=0; the next entry's timestamp is counted from 0.
